sal_axi_traffic_gen: RTL and testbench

//  Synthesizable, parametrised AXI master traffic generator and read-data checker for the DDR2 controller.

---
 rtl/sal_tg_pkg.sv | 18 +
 rtl/sal_tg_addr_gen.sv | 54 +++++
 rtl/sal_axi_traffic_gen.sv | 188 ++++++++++++++++++
 tb/tb_sal_axi_traffic_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_tg_pkg.sv
// rtl/sal_tg_pkg.sv - shared types, constants and data pattern for the AXI traffic generator
package sal_tg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } tg_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // One 32-bit lane of the data pattern; the beat address itself, replicated by the caller.
    function automatic logic [31:0] pattern_lane(input logic [31:0] beat_addr);
        return beat_addr;
    endfunction

endpackage

// File: rtl/sal_tg_addr_gen.sv
// rtl/sal_tg_addr_gen.sv - address-channel burst issuer with outstanding-burst throttle
module sal_tg_addr_gen #(
    parameter int ADDR_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [CNT_WIDTH-1:0]  num_txn,
    input  logic                  enable,
    input  logic                  ready,
    input  logic                  retire,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  done
);

    logic [CNT_WIDTH-1:0] sent_q;
    logic [3:0]           outst_q;
    logic                 hs;
    logic                 retire_ok;

    // Valid is a pure function of registered state, so it cannot drop before its handshake.
    assign valid     = enable && (sent_q < num_txn) && (outst_q < 4'(MAX_OUTSTANDING));
    assign hs        = valid && ready;
    assign retire_ok = retire && (outst_q != 4'd0);
    assign done      = (sent_q == num_txn) && (outst_q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= '0;
            sent_q  <= '0;
            outst_q <= '0;
        end else if (load) begin
            addr    <= base;
            sent_q  <= '0;
            outst_q <= '0;
        end else begin
            if (hs) begin
                addr   <= addr + stride;
                sent_q <= sent_q + 1'b1;
            end
            if (hs && !retire_ok) begin
                outst_q <= outst_q + 4'd1;
            end else if (!hs && retire_ok) begin
                outst_q <= outst_q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/sal_axi_traffic_gen.sv
// rtl/sal_axi_traffic_gen.sv - AXI master write-then-read traffic generator with read-data checker
module sal_axi_traffic_gen
    import sal_tg_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 128,
    parameter int ID_WIDTH        = 4,
    parameter int LEN_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH-1:0]   stride,
    input  logic [CNT_WIDTH-1:0]    num_txn,
    input  logic [LEN_WIDTH-1:0]    burst_len,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    err_cnt,
    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [ADDR_WIDTH-1:0]   aw_addr,
    output logic [ID_WIDTH-1:0]     aw_id,
    output logic [LEN_WIDTH-1:0]    aw_len,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    w_last,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [ID_WIDTH-1:0]     b_id,
    input  logic [1:0]              b_resp,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    output logic [ADDR_WIDTH-1:0]   ar_addr,
    output logic [ID_WIDTH-1:0]     ar_id,
    output logic [LEN_WIDTH-1:0]    ar_len,
    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [DATA_WIDTH-1:0]   r_data,
    input  logic [ID_WIDTH-1:0]     r_id,
    input  logic [1:0]              r_resp,
    input  logic                    r_last
);

    localparam int LANES = DATA_WIDTH / 32;
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    tg_state_e             state_q, state_d;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  err_cnt_q;
    logic                  start_ok, aw_done, ar_done;
    logic                  aw_hs, w_hs, b_hs, r_hs, r_err, b_err, err_inc;
    logic [LEN_WIDTH-1:0]  w_beat_q, r_beat_q;
    logic [ADDR_WIDTH-1:0] w_burst_q, r_burst_q, w_beat_addr, r_beat_addr;
    logic [4:0]            w_credit_q;
    logic [DATA_WIDTH-1:0] r_exp;

    assign busy     = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign done     = (state_q == ST_DONE);
    assign start_ok = start && !busy;
    assign b_ready  = (state_q == ST_WRITE);
    assign r_ready  = (state_q == ST_READ);
    assign err_cnt  = err_cnt_q;
    assign aw_id    = '0;
    assign ar_id    = '0;
    assign aw_len   = len_q;
    assign ar_len   = len_q;

    sal_tg_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_aw_gen (
        .clk(clk), .rst(rst), .load(start_ok), .base(base_addr), .stride(stride_q),
        .num_txn(num_q), .enable(state_q == ST_WRITE), .ready(aw_ready), .retire(b_hs),
        .valid(aw_valid), .addr(aw_addr), .done(aw_done)
    );

    sal_tg_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_ar_gen (
        .clk(clk), .rst(rst), .load(start_ok), .base(base_addr), .stride(stride_q),
        .num_txn(num_q), .enable(state_q == ST_READ), .ready(ar_ready), .retire(r_hs && r_last),
        .valid(ar_valid), .addr(ar_addr), .done(ar_done)
    );

    assign aw_hs = aw_valid && aw_ready;
    assign w_hs  = w_valid && w_ready;
    assign b_hs  = b_valid && b_ready;
    assign r_hs  = r_valid && r_ready;

    // w_credit counts accepted AWs whose W burst is unfinished; it goes to -1 when a W burst
    // completes ahead of its AW, which holds off the next burst until that AW is accepted.
    assign w_valid = (state_q == ST_WRITE) &&
                     ((!w_credit_q[4] && w_credit_q != 5'd0) || (w_credit_q == 5'd0 && aw_valid));
    assign w_last      = (w_beat_q == len_q);
    assign w_strb      = '1;
    assign w_beat_addr = w_burst_q + ADDR_WIDTH'(w_beat_q) * BEAT_BYTES;
    assign w_data      = {LANES{pattern_lane(32'(w_beat_addr))}};

    assign r_beat_addr = r_burst_q + ADDR_WIDTH'(r_beat_q) * BEAT_BYTES;
    assign r_exp       = {LANES{pattern_lane(32'(r_beat_addr))}};
    assign r_err = (r_resp != RESP_OKAY) || (r_id != '0) || (mode_q && (r_data != r_exp)) ||
                   (r_last != (r_beat_q == len_q));
    assign b_err   = (b_resp != RESP_OKAY) || (b_id != '0);
    assign err_inc = (b_hs && b_err) || (r_hs && r_err);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (num_txn == '0) state_d = ST_DONE;
                    else               state_d = mode ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: if (aw_done) state_d = ST_READ;
            ST_READ:  if (ar_done) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= 1'b0;
            stride_q  <= '0;
            num_q     <= '0;
            len_q     <= '0;
            err_cnt_q <= '0;
        end else if (start_ok) begin
            mode_q    <= mode;
            stride_q  <= stride;
            num_q     <= num_txn;
            len_q     <= burst_len;
            err_cnt_q <= '0;
        end else if (err_inc && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_beat_q   <= '0;
            w_burst_q  <= '0;
            w_credit_q <= '0;
            r_beat_q   <= '0;
            r_burst_q  <= '0;
        end else if (start_ok) begin
            w_beat_q   <= '0;
            w_burst_q  <= base_addr;
            w_credit_q <= '0;
            r_beat_q   <= '0;
            r_burst_q  <= base_addr;
        end else begin
            if (aw_hs && !(w_hs && w_last)) w_credit_q <= w_credit_q + 5'd1;
            else if (!aw_hs && w_hs && w_last) w_credit_q <= w_credit_q - 5'd1;
            if (w_hs) begin
                if (w_last) begin
                    w_beat_q  <= '0;
                    w_burst_q <= w_burst_q + stride_q;
                end else begin
                    w_beat_q <= w_beat_q + 1'b1;
                end
            end
            // The beat counter resyncs on r_last even when the slave ends a burst early or late.
            if (r_hs) begin
                if (r_last) begin
                    r_beat_q  <= '0;
                    r_burst_q <= r_burst_q + stride_q;
                end else begin
                    r_beat_q <= r_beat_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sal_axi_traffic_gen.sv
// tb/tb_sal_axi_traffic_gen.sv - scoreboard bench with a behavioural AXI slave for sal_axi_traffic_gen
module tb_sal_axi_traffic_gen;

    localparam int AW = 32, DW = 128, IW = 4, LW = 4, CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, mode;
    logic [AW-1:0] base_addr, stride;
    logic [CW-1:0] num_txn;
    logic [LW-1:0] burst_len;
    logic          busy, done;
    logic [CW-1:0] err_cnt;
    logic          aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic          ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [IW-1:0] aw_id, ar_id, b_id, r_id;
    logic [LW-1:0] aw_len, ar_len;
    logic [DW-1:0] w_data, r_data;
    logic [DW/8-1:0] w_strb;
    logic [1:0]    b_resp, r_resp;

    sal_axi_traffic_gen dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr), .stride(stride),
        .num_txn(num_txn), .burst_len(burst_len), .busy(busy), .done(done), .err_cnt(err_cnt),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_resp(r_resp),
        .r_last(r_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;

    logic [AW-1:0] aw_exp_q[$], ar_exp_q[$], ar_log[$], rd_addr_q[$];
    logic [DW:0]   w_exp_q[$];

    logic [LW-1:0] cfg_len = '0;
    int  cfg_num = 0, cfg_cor_burst = -1, cfg_cor_beat = -1, cfg_bad_b = -1, r_release = 0;
    bit  aw_ready_en = 1'b1;
    int  b_pend = 0, b_seen = 0, r_beat = 0, r_burst = 0;
    int  aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, ar_at_first_r = 0;
    bit  r_seen = 0, ar_stalled = 0, any_valid = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: handshake with empty scoreboard queue", name);
    endtask

    // Slave and monitor: drive at negedge, then score the handshakes the next posedge will take.
    initial begin
        logic [AW-1:0] beat_addr;
        aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; b_id = '0; b_resp = '0;
        r_valid = 0; r_data = '0; r_id = '0; r_resp = '0; r_last = 0;
        forever begin
            @(negedge clk);
            aw_ready = aw_ready_en;
            w_ready  = 1'b1;
            ar_ready = 1'b1;
            b_valid  = (b_pend > 0);
            b_resp   = (b_seen == cfg_bad_b) ? 2'd2 : 2'd0;
            if (rd_addr_q.size() > 0 && cyc >= r_release) begin
                beat_addr = rd_addr_q[0] + AW'(r_beat * 16);
                r_valid   = 1'b1;
                r_data    = {4{beat_addr}};
                if (r_burst == cfg_cor_burst && r_beat == cfg_cor_beat) r_data[0] = ~r_data[0];
                r_last    = (r_beat == int'(cfg_len));
            end else begin
                r_valid = 1'b0;
                r_data  = '0;
                r_last  = 1'b0;
            end
            #1;
            if (aw_valid || w_valid || ar_valid) any_valid = 1'b1;
            if (!ar_valid && rd_addr_q.size() == 4 && ar_hs_cnt < cfg_num) ar_stalled = 1'b1;
            if (aw_valid && aw_ready) begin
                aw_hs_cnt++;
                if (aw_exp_q.size() == 0) fail_now("aw_extra");
                else check("aw", {aw_len, aw_id, aw_addr}, {cfg_len, 4'h0, aw_exp_q.pop_front()});
            end
            if (w_valid && w_ready) begin
                w_hs_cnt++;
                if (w_exp_q.size() == 0) fail_now("w_extra");
                else check("w", {w_last, w_strb, w_data}, {w_exp_q[0][DW], 16'hFFFF, w_exp_q[0][DW-1:0]});
                if (w_exp_q.size() != 0) void'(w_exp_q.pop_front());
                if (w_last) b_pend++;
            end
            if (b_valid && b_ready) begin
                b_pend--;
                b_seen++;
            end
            if (ar_valid && ar_ready) begin
                ar_hs_cnt++;
                ar_log.push_back(ar_addr);
                rd_addr_q.push_back(ar_addr);
                if (ar_exp_q.size() == 0) fail_now("ar_extra");
                else check("ar", {ar_len, ar_id, ar_addr}, {cfg_len, 4'h0, ar_exp_q.pop_front()});
            end
            if (r_valid && r_ready) begin
                if (!r_seen) begin
                    r_seen = 1'b1;
                    ar_at_first_r = ar_hs_cnt;
                end
                if (r_last) begin
                    void'(rd_addr_q.pop_front());
                    r_burst++;
                    r_beat = 0;
                end else begin
                    r_beat++;
                end
            end
        end
    end

    task automatic setup(input int n, input int len, input int cor_burst, input int cor_beat,
                         input int bad_b, input int delay);
        @(negedge clk);
        #3;
        aw_exp_q.delete(); ar_exp_q.delete(); w_exp_q.delete(); ar_log.delete(); rd_addr_q.delete();
        b_pend = 0; b_seen = 0; r_beat = 0; r_burst = 0;
        aw_hs_cnt = 0; w_hs_cnt = 0; ar_hs_cnt = 0; ar_at_first_r = 0;
        r_seen = 0; ar_stalled = 0; any_valid = 0;
        cfg_num = n; cfg_len = LW'(len); cfg_cor_burst = cor_burst; cfg_cor_beat = cor_beat;
        cfg_bad_b = bad_b; r_release = cyc + delay;
    endtask

    task automatic run(input bit m, input logic [AW-1:0] base, input logic [AW-1:0] str,
                       input int n, input int len, input int cor_burst, input int cor_beat,
                       input int bad_b, input int delay, input int exp_err, input bit poke);
        logic [AW-1:0] a, wa;
        setup(n, len, cor_burst, cor_beat, bad_b, delay);
        for (int k = 0; k < n; k++) begin
            a = base + str * AW'(k);
            if (m) begin
                aw_exp_q.push_back(a);
                for (int b = 0; b <= len; b++) begin
                    wa = a + AW'(b * 16);
                    w_exp_q.push_back({(b == len), {4{wa}}});
                end
            end
            ar_exp_q.push_back(a);
        end
        @(negedge clk);
        start = 1'b1; mode = m; base_addr = base; stride = str;
        num_txn = CW'(n); burst_len = LW'(len);
        @(negedge clk);
        start = 1'b0; mode = !m; base_addr = 32'hDEAD_BEE0; stride = 32'h100;
        num_txn = 16'd2; burst_len = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            start = poke && (i == 10);
            @(negedge clk);
            if (done) break;
        end
        start = 1'b0;
        #2;
        check("done", done, 1);
        check("busy_after", busy, 0);
        check("err_cnt", err_cnt, exp_err);
        check("queues_left", aw_exp_q.size() + w_exp_q.size() + ar_exp_q.size(), 0);
        check("ar_count", ar_hs_cnt, n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; stride = '0;
        num_txn = '0; burst_len = '0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_flags", {busy, done, aw_valid, w_valid, ar_valid, b_ready, r_ready}, 0);
        check("reset_err", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        setup(0, 0, -1, -1, -1, 0);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; num_txn = '0; burst_len = 4'd3; base_addr = '0; stride = 32'h40;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("num0_done", done, 1);
        check("num0_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("num0_no_valid", any_valid, 0);

        run(1'b1, 32'h0, 32'h40, 8, 3, -1, -1, -1, 0, 0, 1'b0);
        check("a_aw_cnt", aw_hs_cnt, 8);
        check("a_w_cnt", w_hs_cnt, 32);
        check("a_last_ar", ar_log[7], 32'h1C0);

        run(1'b1, 32'h1000, 32'h20, 4, 1, -1, -1, -1, 0, 0, 1'b1);

        run(1'b0, 32'h2000, 32'h40, 8, 3, -1, -1, -1, 50, 0, 1'b0);
        check("b_ar_before_r", ar_at_first_r, 4);
        check("b_ar_stalled", ar_stalled, 1);

        run(1'b1, 32'h0, 32'h40, 8, 3, 5, 2, -1, 0, 1, 1'b0);
        run(1'b1, 32'h0, 32'h40, 8, 3, -1, -1, 3, 0, 1, 1'b0);

        run(1'b0, 32'hFFFF_FFC0, 32'h40, 3, 3, -1, -1, -1, 0, 0, 1'b0);
        check("wrap_ar0", ar_log[0], 32'hFFFF_FFC0);
        check("wrap_ar1", ar_log[1], 32'h0000_0000);
        check("wrap_ar2", ar_log[2], 32'h0000_0040);

        setup(8, 3, -1, -1, -1, 0);
        aw_ready_en = 1'b0;
        for (int b = 0; b < 4; b++) w_exp_q.push_back({(b == 3), {4{32'h100 + 32'(b * 16)}}});
        @(negedge clk);
        start = 1'b1; mode = 1'b1; base_addr = 32'h100; stride = 32'h40; num_txn = 16'd8; burst_len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        check("rst_aw_held", {aw_valid, busy}, 2'b11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("rst_mid_flags", {aw_valid, w_valid, ar_valid, busy, done}, 0);
        check("rst_mid_err", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        aw_ready_en = 1'b1;

        run(1'b1, 32'h400, 32'h40, 2, 3, -1, -1, -1, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
